// File: rtl/fp_sub_seq.sv
// ---------------------------------------------------------------------------
// fp_sub_seq
// Sequential IEEE-754 single-precision subtractor computing A - B.
// Subtraction is done as an addition of A and B with its sign inverted.
// The operand with the larger magnitude is kept as "max". The smaller operand's
// mantissa is aligned one bit per cycle, then added or subtracted in one cycle.
// The result is normalised one bit per cycle. Rounding is truncation.
//
// Ports
//   clk        : sole clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, has priority over an accept
//   in_valid   : operand pair A, B present
//   in_ready   : block accepts operands (high only in IDLE)
//   A, B       : single-precision operands
//   out_valid  : result/exception/overflow valid (high only in DONE)
//   out_ready  : consumer accepts the result
//   result     : packed single-precision difference
//   exception  : an operand had exponent 8'hFF (result forced to +0)
//   overflow   : result exponent reached 8'hFF
//
// Configuration
//   FP_SUB_SAT_EN : when defined, an overflowing result saturates to the
//                   largest finite magnitude {sign, 8'hFE, 23'h7FFFFF}.
//                   When undefined, it becomes infinity {sign, 8'hFF, 23'h0}.
// ---------------------------------------------------------------------------
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ARITH,
    NORM,
    DONE
  } state_t;

  state_t state, state_next;

  // Working registers of the datapath
  logic        sign_max;
  logic        sign_min;
  logic [7:0]  exp_work;
  logic [23:0] mant_max;
  logic [23:0] mant_min;
  logic [24:0] mant_work;
  logic [4:0]  align_cnt;

  // Decoded view of the incoming operand pair
  logic [31:0] b_neg;
  logic        a_is_max;
  logic [31:0] op_max;
  logic [31:0] op_min;
  logic [7:0]  exp_diff;
  logic [4:0]  align_init;
  logic        in_exc;

  // Normalisation step results
  logic        norm_done;
  logic [31:0] norm_result;
  logic        norm_ovf;
  logic [23:0] norm_shift_mant;
  logic [7:0]  norm_shift_exp;
  logic [7:0]  norm_inc_exp;
  logic [31:0] ovf_pattern;

  // Operand decode. B is negated up front so the rest of the datapath
  // is a plain signed-magnitude adder. Ties in magnitude pick A as max.
  // Ordering by A[30:0] implies exp_max >= exp_min, so the exponent
  // difference cannot underflow.
  always_comb begin
    b_neg      = {~B[31], B[30:0]};
    a_is_max   = (A[30:0] >= B[30:0]);
    op_max     = a_is_max ? A : b_neg;
    op_min     = a_is_max ? b_neg : A;
    exp_diff   = op_max[30:23] - op_min[30:23];
    align_init = (exp_diff > 8'd25) ? 5'd25 : exp_diff[4:0];
    in_exc     = (A[30:23] == 8'hFF) || (B[30:23] == 8'hFF);
  end

  // Overflow result pattern. It is the only part that differs between builds.
  always_comb begin
`ifdef FP_SUB_SAT_EN
    ovf_pattern = {sign_max, 8'hFE, 23'h7FFFFF};
`else
    ovf_pattern = {sign_max, 8'hFF, 23'h000000};
`endif
  end

  // One normalisation step. The left-shift case decides whether to finish
  // using the already shifted value. This lets NORM end on the cycle of the
  // last shift, so NORM lasts max(1, shifts) cycles. A mantissa whose bit23
  // is still clear at exponent 1 becomes a denormal with exponent 0.
  // A sum of two denormals can carry into bit23; it is then packed as
  // exponent 1.
  always_comb begin
    norm_done       = 1'b0;
    norm_result     = 32'h0;
    norm_ovf        = 1'b0;
    norm_shift_mant = {mant_work[22:0], 1'b0};
    norm_shift_exp  = exp_work - 8'd1;
    norm_inc_exp    = exp_work + 8'd1;
    if (mant_work[24]) begin
      norm_done = 1'b1;
      if (norm_inc_exp == 8'hFF) begin
        norm_ovf    = 1'b1;
        norm_result = ovf_pattern;
      end else begin
        norm_result = {sign_max, norm_inc_exp, mant_work[23:1]};
      end
    end else if (mant_work == 25'd0) begin
      norm_done   = 1'b1;
      norm_result = 32'h0;
    end else if (mant_work[23]) begin
      norm_done   = 1'b1;
      norm_result = {sign_max, (exp_work == 8'd0) ? 8'd1 : exp_work, mant_work[22:0]};
    end else if (exp_work > 8'd1) begin
      if (norm_shift_mant[23]) begin
        norm_done   = 1'b1;
        norm_result = {sign_max, norm_shift_exp, norm_shift_mant[22:0]};
      end else if (norm_shift_exp == 8'd1) begin
        norm_done   = 1'b1;
        norm_result = {sign_max, 8'd0, norm_shift_mant[22:0]};
      end
    end else begin
      norm_done   = 1'b1;
      norm_result = {sign_max, 8'd0, mant_work[22:0]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. Operands with an exponent of 8'hFF
  // go straight to DONE. DONE never accepts a new pair on its release edge.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = in_exc ? DONE : ALIGN;
        end
      end
      ALIGN: begin
        if (align_cnt <= 5'd1) begin
          state_next = ARITH;
        end
      end
      ARITH: begin
        state_next = NORM;
      end
      NORM: begin
        if (norm_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. Results are written only on the way into DONE and
  // held there. Reset discards any operation that is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_max  <= 1'b0;
      sign_min  <= 1'b0;
      exp_work  <= 8'd0;
      mant_max  <= 24'd0;
      mant_min  <= 24'd0;
      mant_work <= 25'd0;
      align_cnt <= 5'd0;
      result    <= 32'h0;
      exception <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_max  <= op_max[31];
            sign_min  <= op_min[31];
            exp_work  <= op_max[30:23];
            mant_max  <= {(op_max[30:23] != 8'd0), op_max[22:0]};
            mant_min  <= {(op_min[30:23] != 8'd0), op_min[22:0]};
            align_cnt <= align_init;
            overflow  <= 1'b0;
            exception <= in_exc;
            if (in_exc) begin
              result <= 32'h0;
            end
          end
        end
        ALIGN: begin
          if (align_cnt != 5'd0) begin
            mant_min  <= {1'b0, mant_min[23:1]};
            align_cnt <= align_cnt - 5'd1;
          end
        end
        ARITH: begin
          if (sign_max == sign_min) begin
            mant_work <= {1'b0, mant_max} + {1'b0, mant_min};
          end else begin
            mant_work <= {1'b0, mant_max} - {1'b0, mant_min};
          end
        end
        NORM: begin
          if (norm_done) begin
            result   <= norm_result;
            overflow <= norm_ovf;
          end else begin
            mant_work <= {1'b0, norm_shift_mant};
            exp_work  <= norm_shift_exp;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_sub_seq
// Directed testbench for fp_sub_seq. It uses hand-computed A - B vectors.
// Latency is counted in edges, and the accept edge counts as edge 1.
// ---------------------------------------------------------------------------
module tb_fp_sub_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        exception;
  logic        overflow;

  int checks;
  int failures;

  fp_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception),
    .overflow  (overflow)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation from IDLE. Inputs are driven on the falling edge and
  // outputs are sampled 1 unit after the rising edge. The wait for out_valid
  // is bounded; a timeout shows up as a wrong latency.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc,
                       output logic ovf, output int lat);
    @(negedge clk);
    A = a;
    B = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    exc = exception;
    ovf = overflow;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Reset state after power-up reset
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = 32'h0;
    B = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got %h want 00000000", result); end
    checks++;
    if (exception !== 1'b0) begin failures++; $display("[TB] FAIL reset_exception got %b want 0", exception); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Arithmetic vectors. They cover the carry, cancellation, long
  // normalisation, alignment near and beyond the 25-bit clamp, and denormal
  // results.
  task automatic test_arith();
    logic [31:0] va [11];
    logic [31:0] vb [11];
    logic [31:0] vr [11];
    int          vl [11];
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    int          lat;
    va = '{32'h40400000, 32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h40400000,
           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00C00000, 32'h01200000};
    vb = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 32'hBF800000,
           32'h3F7FFFFF, 32'h33800000, 32'h00000001, 32'h00800000, 32'h01000000};
    vr = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h00000000, 32'hC0000000, 32'h40800000,
           32'h34000000, 32'h3F800000, 32'h3F800000, 32'h00400000, 32'h00400000};
    vl = '{4, 4, 4, 4, 4, 4, 26, 27, 28, 4, 4};
    for (int i = 0; i < 11; i++) begin
      do_op(va[i], vb[i], res, exc, ovf, lat);
      checks++;
      if (res !== vr[i]) begin failures++; $display("[TB] FAIL arith_result[%0d] got %h want %h", i, res, vr[i]); end
      checks++;
      if (lat != vl[i]) begin failures++; $display("[TB] FAIL arith_latency[%0d] got %0d want %0d", i, lat, vl[i]); end
      checks++;
      if (exc !== 1'b0 || ovf !== 1'b0) begin failures++; $display("[TB] FAIL arith_flags[%0d] got exc=%b ovf=%b want 0 0", i, exc, ovf); end
    end
  endtask

  // Overflow for both result signs. The result pattern depends on the build.
  task automatic test_overflow();
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    int          lat;
    logic [31:0] want_pos;
    logic [31:0] want_neg;
`ifdef FP_SUB_SAT_EN
    want_pos = 32'h7F7FFFFF;
    want_neg = 32'hFF7FFFFF;
`else
    want_pos = 32'h7F800000;
    want_neg = 32'hFF800000;
`endif
    do_op(32'h7F7FFFFF, 32'hFF7FFFFF, res, exc, ovf, lat);
    checks++;
    if (res !== want_pos || ovf !== 1'b1 || exc !== 1'b0) begin
      failures++; $display("[TB] FAIL overflow_pos got %h ovf=%b exc=%b want %h 1 0", res, ovf, exc, want_pos);
    end
    checks++;
    if (lat != 4) begin failures++; $display("[TB] FAIL overflow_latency got %0d want 4", lat); end
    do_op(32'hFF7FFFFF, 32'h7F7FFFFF, res, exc, ovf, lat);
    checks++;
    if (res !== want_neg || ovf !== 1'b1) begin
      failures++; $display("[TB] FAIL overflow_neg got %h ovf=%b want %h 1", res, ovf, want_neg);
    end
  endtask

  // Operands with exponent 8'hFF skip the pipeline and give +0 with exception set
  task automatic test_exception();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    int          lat;
    va = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
    vb = '{32'h3F800000, 32'hFFC00000, 32'h7F800000};
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], res, exc, ovf, lat);
      checks++;
      if (res !== 32'h0 || exc !== 1'b1 || ovf !== 1'b0) begin
        failures++; $display("[TB] FAIL exception[%0d] got %h exc=%b ovf=%b want 00000000 1 0", i, res, exc, ovf);
      end
      checks++;
      if (lat != 1) begin failures++; $display("[TB] FAIL exception_latency[%0d] got %0d want 1", i, lat); end
    end
  endtask

  // DONE holds its outputs until out_ready and ignores a pair on the release edge
  task automatic test_back_to_back();
    int          lat;
    logic        stable;
    @(negedge clk);
    A = 32'h40400000;
    B = 32'h3F800000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40000000) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (stable !== 1'b1) begin failures++; $display("[TB] FAIL hold_done got unstable result=%h want 40000000 held", result); end
    @(negedge clk);
    A = 32'h40400000;
    B = 32'hBF800000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL release_no_accept got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL second_accept got in_ready=%b want 0", in_ready); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (result !== 32'h40800000 || lat != 4) begin
      failures++; $display("[TB] FAIL second_result got %h lat=%0d want 40800000 lat=4", result, lat);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Reset in the middle of ALIGN, and reset taking priority over an accept
  task automatic test_reset_midop();
    logic seen_valid;
    @(negedge clk);
    A = 32'h3F800000;
    B = 32'h00000001;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midop_reset got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || result !== 32'h0) begin
      failures++; $display("[TB] FAIL midop_discard got seen_valid=%b result=%h want 0 00000000", seen_valid, result);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    A = 32'h7F800000;
    B = 32'h3F800000;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || exception !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_priority got out_valid=%b exc=%b in_ready=%b want 0 0 1", out_valid, exception, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_priority_after got out_valid=%b want 0", out_valid); end
  endtask

  // Test sequence
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_arith();
    test_overflow();
    test_exception();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_sub_seq.md
FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1: operand pair A, B present.
REQ-004 SHALL have port in_ready, output, 1: block accepts operands; high only in IDLE.
REQ-005 SHALL have ports A and B, input, 32 each: IEEE-754 single-precision operands; block computes A - B.
REQ-006 SHALL have port out_valid, output, 1: result, exception and overflow valid; high only in DONE.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-008 SHALL have port result, output, 32: packed single-precision difference.
REQ-009 SHALL have port exception, output, 1: an operand had exponent 8'hFF.
REQ-010 SHALL have port overflow, output, 1: result exponent reached 8'hFF.

Function
REQ-011 SHALL use FSM states IDLE, ALIGN, ARITH, NORM, DONE; handshake completes on an edge with valid and ready both high.
REQ-012 On acceptance in IDLE: register A, and B with sign inverted (B'); max = larger of A[30:0] vs B[30:0] (tie: A is max); min = the other; next state ALIGN.
REQ-013 Hidden bit SHALL be 1 if exponent nonzero, else 0; mantissas 24 bits.
REQ-014 exception SHALL be set if either exponent is 8'hFF; result then 32'h0 and overflow 0; timing per REQ-022/config.
REQ-015 ALIGN: counter loaded with min(exp_max - exp_min, 25); each cycle with counter nonzero, shift min mantissa right 1 and decrement; exit to ARITH when counter <= 1; ALIGN lasts max(1, min(d,25)) cycles.
REQ-016 ARITH (1 cycle): equal signs -> 25-bit sum; else mant_max - mant_min (never negative); result sign = max sign; next NORM.
REQ-017 NORM: bit24 set -> shift right 1, exponent +1, to DONE in 1 cycle.
REQ-018 NORM: mantissa zero -> result +0 (32'h0), to DONE in 1 cycle.
REQ-019 NORM otherwise: while bit23 clear and exponent > 1, shift left 1 and decrement exponent, one step per cycle; if bit23 still clear at exponent 1, exponent becomes 0 (denormal); NORM lasts max(1, shifts) cycles.
REQ-020 Rounding SHALL be truncation; shifted-out bits discarded.
REQ-021 Overflow (exponent +1 reaches 8'hFF): overflow = 1; result per Configuration.
REQ-022 Latency from accept edge to first cycle with out_valid = 2 + max(1,min(d,25)) + max(1,shifts) edges.
REQ-023 DONE holds result, exception and overflow stable until out_ready; returns to IDLE on that edge; a new operand pair is not accepted in the same cycle.

Reset
REQ-024 rst SHALL force IDLE, in_ready=1, out_valid=0, result=32'h0, exception=0, overflow=0, counters cleared, from any state, including mid-operation; the in-flight operation is discarded.
REQ-025 rst SHALL take priority over an accept in the same cycle.

Configuration
REQ-026 With macro FP_SUB_SAT_EN defined, overflow result SHALL be {sign, 8'hFE, 23'h7FFFFF}.
REQ-027 Without FP_SUB_SAT_EN, overflow result SHALL be {sign, 8'hFF, 23'h0}; overflow flag behaves identically in both builds.
REQ-028 In both builds, exception operands skip ALIGN, ARITH and NORM: IDLE -> DONE, out_valid 1 edge after accept.

Verification
REQ-029 A=32'h40400000, B=32'h3F800000 -> result 32'h40000000; out_valid 4 edges after accept.
REQ-030 A=32'h3F800000, B=32'hBF800000 -> result 32'h40000000 (carry path).
REQ-031 A=32'h3FC00000, B=32'h3F800000 -> result 32'h3F000000 (one left shift).
REQ-032 A=B=32'h3F800000 -> result 32'h00000000.
REQ-033 A=32'h7F7FFFFF, B=32'hFF7FFFFF -> overflow=1; result 32'h7F7FFFFF with FP_SUB_SAT_EN, 32'h7F800000 without.
REQ-034 A=32'h7F800000, any B -> exception=1, result 0; rst pulsed in ALIGN -> IDLE next edge, out_valid stays 0.
